gemm_tile_scheduler: RTL
========================

// Module: gemm_tile_scheduler
// PURPOSE
//  Sequences deit_core over a tiled GEMM job: (M rows) x (K_TILES) x (N_TILES).
//  Per N tile: issues K_TILES core runs (first overwrites, rest accumulate in the bank),
//  then one accumulator drain. Sits between the host/CSR command interface and deit_core.
//  Also drives buffer tile indices and a busy-cycle counter.
// PARAMETERS
//  M_WIDTH   8   width of row count M (max 255; DeiT token count 197 fits)
//  KT_WIDTH  8   width of K-tile count / k index
//  NT_WIDTH  8   width of N-tile count / n index
//  CYC_WIDTH 32  width of core_compute_cycles and the perf counter
// PORTS
//  clk                 in   1         clock
//  rst_n               in   1         asynchronous, active-low reset
//  cmd_valid           in   1         job request
//  cmd_ready           out  1         high only in IDLE
//  cmd_m               in   M_WIDTH   rows per tile (= compute cycles)
//  cmd_k_tiles         in   KT_WIDTH  K tiles per N tile
//  cmd_n_tiles         in   NT_WIDTH  N tiles
//  cmd_abort           in   1         level; abort the current job
//  core_ap_start       out  1         1-cycle start pulse to deit_core
//  core_compute_cycles out  CYC_WIDTH zero-extended latched M
//  core_acc_mode       out  1         0 = overwrite (k_idx==0), 1 = accumulate
//  core_ap_done        in   1         core completion pulse
//  core_ap_idle        in   1         core idle level
//  tile_k_idx          out  KT_WIDTH  current K tile (to act/weight buffer ctrl)
//  tile_n_idx          out  NT_WIDTH  current N tile
//  drain_start         out  1         1-cycle pulse: read out accumulator for tile_n_idx
//  drain_done          in   1         drain-engine completion pulse
//  busy                out  1         high in every state except IDLE
//  job_done            out  1         1-cycle pulse: job completed normally
//  job_aborted         out  1         1-cycle pulse: job ended by abort
//  err_cfg             out  1         1-cycle pulse: zero M/K/N rejected
//  perf_busy_cycles    out  CYC_WIDTH cycles spent busy in last job, saturating
// BEHAVIOUR
//  Reset: state=IDLE; all pulses, busy, indices, acc_mode, compute_cycles, perf = 0; cmd_ready=1.
//  FSM: IDLE -> START -> RUN -> (START | DRAIN) ; DRAIN -> DRAIN_WAIT -> (START | FIN) ;
//       FIN -> IDLE ; any busy state --abort--> ABORT_WAIT -> IDLE.
//  IDLE: accept on cmd_valid&&cmd_ready; latch M/K/N; k_idx=n_idx=0; clear perf.
//   Any field zero -> err_cfg pulse next cycle, stay IDLE, no core activity.
//  START: core_ap_start pulses in the first START cycle with core_ap_idle=1 (cmd accept T ->
//   start at T+1 earliest); acc_mode/compute_cycles/indices stable from START until RUN exits.
//  RUN: wait core_ap_done. k_idx<K-1: k_idx++, ->START. Else ->DRAIN.
//  DRAIN: drain_start pulse (1 cycle), ->DRAIN_WAIT. Drain never overlaps a core run.
//  DRAIN_WAIT: on drain_done: n_idx<N-1: n_idx++, k_idx=0, ->START; else ->FIN.
//  FIN: job_done pulse, ->IDLE (cmd_ready high next cycle).
//  Abort (checked in START/RUN/DRAIN/DRAIN_WAIT): never cuts a core run mid-flight.
//   In START before pulse: ->IDLE via ABORT_WAIT at once. In RUN: wait ap_done, then exit.
//   In DRAIN_WAIT: wait drain_done. ABORT_WAIT exits when core_ap_idle=1; job_aborted pulse.
//   Abort same cycle as ap_done/drain_done: abort wins; no further start/drain, no job_done.
//  Stray core_ap_done outside RUN / drain_done outside DRAIN_WAIT: ignored.
//  perf_busy_cycles increments each busy cycle, saturates at all-ones, holds after job.
//  Reset mid-job: immediate return to reset values; no pulses emitted.
//  Index compare uses latched count minus 1 at full width (K=1/N=1 legal; no wrap).
// STRUCTURE
//  Shared pkg (deit_sched_pkg.vh): FSM state localparams, width defaults, ACC_MODE_* codes.
//  Sub-module: tile_index_counter -- nested k/n counters with clear, k_last/n_last flags.
//  FSM + pulse generation + perf counter stay in this module.
// TESTING
//  M=4,K=1,N=1 -> 1 ap_start (cycles=4, acc_mode=0), 1 drain_start (n=0), job_done once.
//  M=197,K=3,N=2 -> 6 starts, acc_mode 0,1,1,0,1,1; drain after 3rd,6th with n_idx 0,1.
//  K=0 -> err_cfg 1 pulse, no ap_start/drain_start, cmd_ready stays 1.
//  Abort during RUN of k=1 in K=3 -> wait ap_done, no more starts/drains, job_aborted, no done.
//  core_ap_idle low 5 cycles in START -> ap_start delayed to first idle cycle, exactly one pulse.
//  rst_n asserted in DRAIN_WAIT -> all outputs reset async; cmd_ready=1, new job runs clean.

Source files
------------

// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared definitions for the GEMM tile scheduler: width defaults, accumulate-mode codes
// and the scheduler FSM state encoding.
package gemm_tile_scheduler_pkg;

  localparam int M_WIDTH_DEF   = 8;
  localparam int KT_WIDTH_DEF  = 8;
  localparam int NT_WIDTH_DEF  = 8;
  localparam int CYC_WIDTH_DEF = 32;

  localparam logic ACC_MODE_OVERWRITE = 1'b0;
  localparam logic ACC_MODE_ACCUM     = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_DRAIN,
    ST_DRAIN_WAIT,
    ST_FIN,
    ST_ABORT_WAIT
  } sched_state_t;

endpackage

// File: rtl/gemm_tile_scheduler_tile_index_counter.sv
// Nested K/N tile counters: K returns to 0 on every N step. The last-tile flags compare
// against the latched counts minus one at full width, so single-tile jobs never wrap.
module gemm_tile_scheduler_tile_index_counter #(
  parameter int KT_WIDTH = 8,
  parameter int NT_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [KT_WIDTH-1:0] k_tiles,
  input  logic [NT_WIDTH-1:0] n_tiles,
  input  logic                k_step,
  input  logic                n_step,
  output logic [KT_WIDTH-1:0] k_idx,
  output logic [NT_WIDTH-1:0] n_idx,
  output logic                k_last,
  output logic                n_last
);

  logic [KT_WIDTH-1:0] k_cnt_q;
  logic [NT_WIDTH-1:0] n_cnt_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values;
  // the reset branch is asynchronous because rst_n sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_idx   <= '0;
      n_idx   <= '0;
      k_cnt_q <= '0;
      n_cnt_q <= '0;
    end else if (load) begin
      k_idx   <= '0;
      n_idx   <= '0;
      k_cnt_q <= k_tiles;
      n_cnt_q <= n_tiles;
    end else if (n_step) begin
      k_idx <= '0;
      n_idx <= n_idx + NT_WIDTH'(1);
    end else if (k_step) begin
      k_idx <= k_idx + KT_WIDTH'(1);
    end
  end

  assign k_last = (k_idx == k_cnt_q - KT_WIDTH'(1));
  assign n_last = (n_idx == n_cnt_q - NT_WIDTH'(1));

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Sequences deit_core over an M x K_TILES x N_TILES GEMM job: K core runs per N tile
// (first overwrites, rest accumulate), then one accumulator drain per N tile.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int M_WIDTH   = M_WIDTH_DEF,
  parameter int KT_WIDTH  = KT_WIDTH_DEF,
  parameter int NT_WIDTH  = NT_WIDTH_DEF,
  parameter int CYC_WIDTH = CYC_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [M_WIDTH-1:0]   cmd_m,
  input  logic [KT_WIDTH-1:0]  cmd_k_tiles,
  input  logic [NT_WIDTH-1:0]  cmd_n_tiles,
  input  logic                 cmd_abort,
  output logic                 core_ap_start,
  output logic [CYC_WIDTH-1:0] core_compute_cycles,
  output logic                 core_acc_mode,
  input  logic                 core_ap_done,
  input  logic                 core_ap_idle,
  output logic [KT_WIDTH-1:0]  tile_k_idx,
  output logic [NT_WIDTH-1:0]  tile_n_idx,
  output logic                 drain_start,
  input  logic                 drain_done,
  output logic                 busy,
  output logic                 job_done,
  output logic                 job_aborted,
  output logic                 err_cfg,
  output logic [CYC_WIDTH-1:0] perf_busy_cycles
);

  sched_state_t state_q, state_d;

  logic                 abort_q;
  logic                 err_q;
  logic [CYC_WIDTH-1:0] cycles_q;
  logic [CYC_WIDTH-1:0] perf_q;

  logic accept, cfg_ok, load, abort_req;
  logic k_step, n_step, k_last, n_last;

  assign accept    = (state_q == ST_IDLE) && cmd_valid;
  assign cfg_ok    = (cmd_m != '0) && (cmd_k_tiles != '0) && (cmd_n_tiles != '0);
  assign load      = accept && cfg_ok;
  // A level abort seen once stays pending until the job has left, even if the host drops it.
  assign abort_req = cmd_abort || abort_q;

  gemm_tile_scheduler_tile_index_counter #(
    .KT_WIDTH (KT_WIDTH),
    .NT_WIDTH (NT_WIDTH)
  ) u_tile_index_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .k_tiles (cmd_k_tiles),
    .n_tiles (cmd_n_tiles),
    .k_step  (k_step),
    .n_step  (n_step),
    .k_idx   (tile_k_idx),
    .n_idx   (tile_n_idx),
    .k_last  (k_last),
    .n_last  (n_last)
  );

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    core_ap_start = 1'b0;
    drain_start   = 1'b0;
    job_done      = 1'b0;
    job_aborted   = 1'b0;
    k_step        = 1'b0;
    n_step        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (load) state_d = ST_START;
      end
      ST_START: begin
        if (abort_req) begin
          state_d = ST_ABORT_WAIT;
        end else if (core_ap_idle) begin
          core_ap_start = 1'b1;
          state_d       = ST_RUN;
        end
      end
      ST_RUN: begin
        // The core run is never cut short; abort is only honoured at its completion.
        if (core_ap_done) begin
          if (abort_req) begin
            state_d = ST_ABORT_WAIT;
          end else if (!k_last) begin
            k_step  = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (abort_req) begin
          state_d = ST_ABORT_WAIT;
        end else begin
          drain_start = 1'b1;
          state_d     = ST_DRAIN_WAIT;
        end
      end
      ST_DRAIN_WAIT: begin
        if (drain_done) begin
          if (abort_req) begin
            state_d = ST_ABORT_WAIT;
          end else if (!n_last) begin
            n_step  = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        job_done = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ABORT_WAIT: begin
        if (core_ap_idle) begin
          job_aborted = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      abort_q  <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
      perf_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && !cfg_ok;
      if (state_q == ST_IDLE) abort_q <= 1'b0;
      else if (cmd_abort)     abort_q <= 1'b1;
      if (load) begin
        cycles_q <= CYC_WIDTH'(cmd_m);
        perf_q   <= '0;
      end else if ((state_q != ST_IDLE) && (perf_q != '1)) begin
        perf_q <= perf_q + CYC_WIDTH'(1);
      end
    end
  end

  assign cmd_ready           = (state_q == ST_IDLE);
  assign busy                = (state_q != ST_IDLE);
  assign err_cfg             = err_q;
  assign core_compute_cycles = cycles_q;
  assign perf_busy_cycles    = perf_q;
  assign core_acc_mode       = (tile_k_idx != '0) ? ACC_MODE_ACCUM : ACC_MODE_OVERWRITE;

endmodule
